hazard_ctrl_unit: RTL and testbench

- Pipeline sequencing controller for the five-stage RV32 core. Sits beside the IF/ID and ID/EX registers.
- Decodes the instruction held in IF/ID and selects the immediate format for the decode-stage immediate generator.
- Tracks in-flight destination registers in an internal scoreboard. Generates PC/IF-ID write enables, ID/EX bubble insertion, branch flushes and EX-stage forwarding selects.
- Provides data-memory freeze handling and saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_unit_pkg.sv | 57 +++++
 rtl/instr_class_decode.sv | 64 ++++++
 rtl/hazard_ctrl_unit.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared encodings and scoreboard payload types for the pipeline hazard controller.
package hazard_ctrl_unit_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_W     = 5;
   localparam int unsigned OPC_W     = 7;
   localparam int unsigned IMM_SEL_W = 2;
   localparam int unsigned FWD_W     = 2;

   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_OPIMM  = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

   localparam logic [IMM_SEL_W-1:0] IMM_I    = 2'b00;
   localparam logic [IMM_SEL_W-1:0] IMM_S    = 2'b01;
   localparam logic [IMM_SEL_W-1:0] IMM_B    = 2'b10;
   localparam logic [IMM_SEL_W-1:0] IMM_NONE = 2'b11;

   localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
   localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
   localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_FREEZE = 2'd2
   } state_e;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             wr;
      logic             ld;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
   } ex_slot_t;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             wr;
   } wb_slot_t;

   // Nearest producer wins; x0 is never forwarded.
   function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                                 input wb_slot_t mem,
                                                 input wb_slot_t wb);
      logic [FWD_W-1:0] sel;
      sel = FWD_RF;
      if (rs != '0) begin
         if (mem.wr && (mem.rd == rs))     sel = FWD_MEM;
         else if (wb.wr && (wb.rd == rs))  sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Classifies an RV32 instruction: register usage, load flag and immediate format.
module instr_class_decode
   import hazard_ctrl_unit_pkg::*;
(
   input  logic [XLEN-1:0]      instr_i,
   output logic [REG_W-1:0]     rd_o,
   output logic [REG_W-1:0]     rs1_o,
   output logic [REG_W-1:0]     rs2_o,
   output logic                 uses_rs1_o,
   output logic                 uses_rs2_o,
   output logic                 writes_rd_o,
   output logic                 is_load_o,
   output logic [IMM_SEL_W-1:0] imm_sel_o
);

   logic wr_c;
   logic unused_fields;

   assign rd_o  = instr_i[11:7];
   assign rs1_o = instr_i[19:15];
   assign rs2_o = instr_i[24:20];
   assign unused_fields = ^{instr_i[31:25], instr_i[14:12]};

   always_comb begin
      wr_c       = 1'b0;
      uses_rs1_o = 1'b0;
      uses_rs2_o = 1'b0;
      is_load_o  = 1'b0;
      imm_sel_o  = IMM_NONE;
      case (instr_i[OPC_W-1:0])
         OP_LOAD: begin
            wr_c       = 1'b1;
            uses_rs1_o = 1'b1;
            is_load_o  = 1'b1;
            imm_sel_o  = IMM_I;
         end
         OP_OPIMM: begin
            wr_c       = 1'b1;
            uses_rs1_o = 1'b1;
            imm_sel_o  = IMM_I;
         end
         OP_STORE: begin
            uses_rs1_o = 1'b1;
            uses_rs2_o = 1'b1;
            imm_sel_o  = IMM_S;
         end
         OP_OP: begin
            wr_c       = 1'b1;
            uses_rs1_o = 1'b1;
            uses_rs2_o = 1'b1;
         end
         OP_BRANCH: begin
            uses_rs1_o = 1'b1;
            uses_rs2_o = 1'b1;
            imm_sel_o  = IMM_B;
         end
         default: ;
      endcase
   end

   // A write to x0 has no architectural effect, so it never creates a dependency.
   assign writes_rd_o = wr_c && (rd_o != '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory freeze,
// EX-stage forwarding selects and saturating stall/flush counters.
module hazard_ctrl_unit
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [XLEN-1:0]      if_id_instr,
   input  logic                 if_id_valid,
   input  logic                 branch_taken_ex,
   input  logic                 dmem_stall,
   output logic                 pc_write,
   output logic                 if_id_write,
   output logic                 if_id_flush,
   output logic                 id_ex_bubble,
   output logic                 ex_mem_write,
   output logic [IMM_SEL_W-1:0] imm_sel,
   output logic [FWD_W-1:0]     fwd_a,
   output logic [FWD_W-1:0]     fwd_b,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   logic [REG_W-1:0]     dec_rd, dec_rs1, dec_rs2;
   logic                 dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_is_load;
   logic [IMM_SEL_W-1:0] dec_imm_sel;

   state_e           state_q, state_d;
   ex_slot_t         ex_q, ex_d;
   wb_slot_t         mem_q, wb_q;
   logic             pend_flush_q, pend_flush_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic hazard_c, flush_req_c, stall_req_c, bubble_c;

   instr_class_decode u_decode (
      .instr_i     (if_id_instr),
      .rd_o        (dec_rd),
      .rs1_o       (dec_rs1),
      .rs2_o       (dec_rs2),
      .uses_rs1_o  (dec_uses_rs1),
      .uses_rs2_o  (dec_uses_rs2),
      .writes_rd_o (dec_writes_rd),
      .is_load_o   (dec_is_load),
      .imm_sel_o   (dec_imm_sel)
   );

   // Load in EX whose result is needed by the instruction in IF/ID.
   assign hazard_c = if_id_valid && ex_q.ld && (ex_q.rd != '0) &&
                     ((dec_uses_rs1 && (dec_rs1 == ex_q.rd)) ||
                      (dec_uses_rs2 && (dec_rs2 == ex_q.rd)));

   // Freeze dominates; a deferred branch fires on the first unfrozen cycle.
   assign flush_req_c = !dmem_stall && (state_q != ST_FLUSH) &&
                        (branch_taken_ex || ((state_q == ST_FREEZE) && pend_flush_q));
   assign stall_req_c = !dmem_stall && !flush_req_c && hazard_c;
   assign bubble_c    = flush_req_c || stall_req_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      pend_flush_d = pend_flush_q;
      if (dmem_stall) begin
         state_d      = ST_FREEZE;
         pend_flush_d = pend_flush_q || branch_taken_ex;
      end else if (flush_req_c) begin
         state_d      = ST_FLUSH;
         pend_flush_d = 1'b0;
      end else begin
         state_d      = ST_RUN;
      end
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_write = 1'b1;
      if (!rst_n) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         ex_mem_write = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (dmem_stall) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         ex_mem_write = 1'b0;
      end else if (flush_req_c) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (stall_req_c) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   assign imm_sel = rst_n ? dec_imm_sel : IMM_NONE;
   assign fwd_a   = rst_n ? fwd_sel(ex_q.rs1, mem_q, wb_q) : FWD_RF;
   assign fwd_b   = rst_n ? fwd_sel(ex_q.rs2, mem_q, wb_q) : FWD_RF;

   // Unused source fields are zeroed so they can never pick up a forward.
   always_comb begin
      ex_d = '0;
      if (!bubble_c && if_id_valid) begin
         ex_d.rd  = dec_rd;
         ex_d.wr  = dec_writes_rd;
         ex_d.ld  = dec_is_load;
         ex_d.rs1 = dec_uses_rs1 ? dec_rs1 : '0;
         ex_d.rs2 = dec_uses_rs2 ? dec_rs2 : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q         <= '0;
         mem_q        <= '0;
         wb_q         <= '0;
         pend_flush_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         pend_flush_q <= pend_flush_d;
         if (!dmem_stall) begin
            ex_q  <= ex_d;
            mem_q <= '{rd: ex_q.rd, wr: ex_q.wr};
            wb_q  <= mem_q;
         end
         if (stall_req_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_req_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit; narrow counters make saturation reachable.
module tb_hazard_ctrl_unit;

   localparam int unsigned CW = 3;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] IMM = 7'b0010011;
   localparam logic [6:0] OPR = 7'b0110011;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        branch_taken_ex;
   logic        dmem_stall;
   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write;
   logic [1:0]  imm_sel, fwd_a, fwd_b;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   hazard_ctrl_unit #(.CNT_W(CW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .if_id_instr     (if_id_instr),
      .if_id_valid     (if_id_valid),
      .branch_taken_ex (branch_taken_ex),
      .dmem_stall      (dmem_stall),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_bubble    (id_ex_bubble),
      .ex_mem_write    (ex_mem_write),
      .imm_sel         (imm_sel),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, op};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ins, input logic br, input logic ds);
      if_id_instr     = ins;
      if_id_valid     = 1'b1;
      branch_taken_ex = br;
      dmem_stall      = ds;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; if_id_instr = '0; if_id_valid = 1'b0; branch_taken_ex = 1'b0; dmem_stall = 1'b0;
      #2;
      drive(enc(LW, 5, 1, 0), 1'b0, 1'b1);
      chk("rst_pc_write",     32'(pc_write), 0);
      chk("rst_if_id_write",  32'(if_id_write), 0);
      chk("rst_ex_mem_write", 32'(ex_mem_write), 0);
      chk("rst_flush",        32'(if_id_flush), 0);
      chk("rst_bubble",       32'(id_ex_bubble), 1);
      chk("rst_fwd_a",        32'(fwd_a), 0);
      chk("rst_imm_sel",      32'(imm_sel), 3);
      dmem_stall = 1'b0;
      tick;
      rst_n = 1'b1;
      #1;
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      chk("rst_flush_cnt", 32'(flush_cnt), 0);

      // lw x5,0(x1) followed by add x6,x5,x2
      drive(enc(LW, 5, 1, 0), 1'b0, 1'b0);
      chk("lw_pc_write", 32'(pc_write), 1);
      chk("lw_bubble",   32'(id_ex_bubble), 0);
      chk("lw_imm_sel",  32'(imm_sel), 0);
      tick;
      drive(enc(OPR, 6, 5, 2), 1'b0, 1'b0);
      chk("lu_pc_write",    32'(pc_write), 0);
      chk("lu_if_id_write", 32'(if_id_write), 0);
      chk("lu_bubble",      32'(id_ex_bubble), 1);
      chk("lu_ex_mem",      32'(ex_mem_write), 1);
      chk("lu_imm_sel",     32'(imm_sel), 3);
      tick;
      drive(enc(OPR, 6, 5, 2), 1'b0, 1'b0);
      chk("lu2_pc_write", 32'(pc_write), 1);
      chk("lu2_bubble",   32'(id_ex_bubble), 0);
      tick;
      // add x3,x1,x2 enters IF/ID while the dependent add sits in EX
      drive(enc(OPR, 3, 1, 2), 1'b0, 1'b0);
      chk("lu_fwd_a",     32'(fwd_a), 1);
      chk("lu_fwd_b",     32'(fwd_b), 0);
      chk("lu_stall_cnt", 32'(stall_cnt), 1);
      tick;
      drive(enc(OPR, 4, 3, 3), 1'b0, 1'b0);
      chk("raw_no_stall", 32'(pc_write), 1);
      chk("raw_bubble",   32'(id_ex_bubble), 0);
      tick;
      drive(enc(OPR, 7, 1, 1), 1'b0, 1'b0);
      chk("raw_fwd_a", 32'(fwd_a), 2);
      chk("raw_fwd_b", 32'(fwd_b), 2);
      tick;
      drive(enc(OPR, 7, 2, 2), 1'b0, 1'b0);
      tick;
      drive(enc(OPR, 8, 7, 0), 1'b0, 1'b0);
      tick;
      drive(enc(OPR, 0, 1, 2), 1'b0, 1'b0);
      chk("prio_fwd_a_mem", 32'(fwd_a), 2);
      chk("x0_fwd_b",       32'(fwd_b), 0);
      tick;
      drive(enc(LW, 0, 1, 0), 1'b0, 1'b0);
      tick;
      // a load to x0 never stalls its consumer
      drive(enc(OPR, 10, 0, 0), 1'b0, 1'b0);
      chk("ldx0_pc_write", 32'(pc_write), 1);
      chk("ldx0_bubble",   32'(id_ex_bubble), 0);
      tick;
      drive(enc(IMM, 0, 0, 0), 1'b0, 1'b0);
      chk("rs0_fwd_a", 32'(fwd_a), 0);
      tick;

      // taken branch
      drive(enc(OPR, 11, 1, 2), 1'b1, 1'b0);
      chk("br_flush",    32'(if_id_flush), 1);
      chk("br_bubble",   32'(id_ex_bubble), 1);
      chk("br_pc_write", 32'(pc_write), 1);
      tick;
      drive(enc(LW, 12, 1, 0), 1'b0, 1'b0);
      chk("br2_flush",     32'(if_id_flush), 0);
      chk("br2_bubble",    32'(id_ex_bubble), 0);
      chk("br2_flush_cnt", 32'(flush_cnt), 1);
      tick;
      // branch concurrent with load-use: flush wins, no stall counted
      drive(enc(OPR, 13, 12, 1), 1'b1, 1'b0);
      chk("brlu_flush",    32'(if_id_flush), 1);
      chk("brlu_pc_write", 32'(pc_write), 1);
      tick;
      drive(enc(OPR, 14, 1, 2), 1'b0, 1'b0);
      chk("brlu_stall_cnt", 32'(stall_cnt), 1);
      chk("brlu_flush_cnt", 32'(flush_cnt), 2);
      chk("brlu_no_flush",  32'(if_id_flush), 0);
      tick;

      // memory freeze for three cycles, branch in the second
      drive(enc(OPR, 15, 14, 14), 1'b0, 1'b1);
      chk("frz1_pc_write", 32'(pc_write), 0);
      chk("frz1_if_id",    32'(if_id_write), 0);
      chk("frz1_ex_mem",   32'(ex_mem_write), 0);
      chk("frz1_bubble",   32'(id_ex_bubble), 0);
      chk("frz1_flush",    32'(if_id_flush), 0);
      tick;
      drive(enc(OPR, 15, 14, 14), 1'b1, 1'b1);
      chk("frz2_pc_write", 32'(pc_write), 0);
      chk("frz2_flush",    32'(if_id_flush), 0);
      tick;
      drive(enc(OPR, 15, 14, 14), 1'b0, 1'b1);
      chk("frz3_ex_mem",    32'(ex_mem_write), 0);
      chk("frz3_flush_cnt", 32'(flush_cnt), 2);
      tick;
      drive(enc(OPR, 15, 14, 14), 1'b0, 1'b0);
      chk("thaw_flush",    32'(if_id_flush), 1);
      chk("thaw_bubble",   32'(id_ex_bubble), 1);
      chk("thaw_pc_write", 32'(pc_write), 1);
      chk("thaw_ex_mem",   32'(ex_mem_write), 1);
      tick;
      drive(enc(OPR, 16, 14, 0), 1'b0, 1'b0);
      chk("thaw2_flush",     32'(if_id_flush), 0);
      chk("thaw2_flush_cnt", 32'(flush_cnt), 3);
      tick;
      // add x14 was held through the freeze and now sits in WB
      drive(enc(IMM, 0, 0, 0), 1'b0, 1'b0);
      chk("hold_fwd_a", 32'(fwd_a), 1);
      tick;

      // counter saturation: 1 + 8 stalls, 3 + 6 flushes, 3-bit counters
      for (int i = 0; i < 8; i++) begin
         drive(enc(LW, 5, 1, 0), 1'b0, 1'b0);
         tick;
         drive(enc(OPR, 6, 5, 2), 1'b0, 1'b0);
         tick;
         drive(enc(OPR, 6, 5, 2), 1'b0, 1'b0);
         tick;
      end
      chk("sat_stall_cnt", 32'(stall_cnt), 7);
      for (int i = 0; i < 6; i++) begin
         drive(enc(IMM, 0, 0, 0), 1'b1, 1'b0);
         tick;
         drive(enc(IMM, 0, 0, 0), 1'b0, 1'b0);
         tick;
      end
      chk("sat_flush_cnt", 32'(flush_cnt), 7);

      // reset mid-freeze with a pending flush
      drive(enc(IMM, 0, 0, 0), 1'b1, 1'b1);
      tick;
      drive(enc(IMM, 0, 0, 0), 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mrst_pc_write",  32'(pc_write), 0);
      chk("mrst_bubble",    32'(id_ex_bubble), 1);
      chk("mrst_flush",     32'(if_id_flush), 0);
      chk("mrst_imm_sel",   32'(imm_sel), 3);
      chk("mrst_stall_cnt", 32'(stall_cnt), 0);
      chk("mrst_flush_cnt", 32'(flush_cnt), 0);
      tick;
      dmem_stall = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("post_flush",    32'(if_id_flush), 0);
      chk("post_bubble",   32'(id_ex_bubble), 0);
      chk("post_pc_write", 32'(pc_write), 1);
      tick;
      chk("post_flush_cnt", 32'(flush_cnt), 0);
      chk("post_stall_cnt", 32'(stall_cnt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
